// File: rtl/smash_rate_meter_pkg.sv
// Shared state encoding and default sizing for the smash rate meter and its
// display/score neighbours.
package smash_rate_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_WINDOW_CYCLES = 1000;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/smash_window_timer.sv
// Window timer for the smash rate meter: clearable up-counter that holds at the
// last window cycle instead of wrapping, and flags that cycle as expire.
module smash_window_timer
  import smash_rate_meter_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TMR_W-1:0] LAST = TMR_W'(WINDOW_CYCLES - 1);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && (timer != LAST)) begin
      timer <= timer + 1'b1;
    end
  end

  assign expire = (timer == LAST);

endmodule

// File: rtl/smash_rate_meter.sv
// Scores smash-detector press pulses over a timed window opened by the first press.
// Optional best-score register enabled by defining SMASH_BEST_SCORE_EN.
module smash_rate_meter
  import smash_rate_meter_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             press,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] result,
  output logic             done,
  output logic [CNT_W-1:0] best
);

  state_t           state, state_nxt;
  logic             tmr_clear, tmr_en, expire;
  logic [CNT_W-1:0] count_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // The timer value equals the window cycle index: it is 0 on the first-press
  // cycle in ARMED and steps along with that press into RUN.
  smash_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .enable(tmr_en),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (start) begin
          state_nxt = ST_ARMED;
          count_nxt = '0;
        end
      end
      ST_ARMED: begin
        if (press) begin
          state_nxt = ST_RUN;
          tmr_en    = 1'b1;
          count_nxt = CNT_W'(1);
        end else begin
          tmr_clear = 1'b1;
        end
      end
      ST_RUN: begin
        tmr_en = 1'b1;
        if (press) count_nxt = sat_inc(count);
        if (expire) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        tmr_clear = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // result is captured on the way into DONE so it is valid alongside done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      result <= '0;
    end else begin
      count <= count_nxt;
      if ((state == ST_RUN) && expire) result <= count_nxt;
    end
  end

`ifdef SMASH_BEST_SCORE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best <= '0;
    end else if ((state == ST_DONE) && (count > best)) begin
      best <= count;
    end
  end
`else
  assign best = '0;
`endif

  assign busy = (state == ST_ARMED) || (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_smash_rate_meter.sv
// Randomized self-checking bench for smash_rate_meter against a press-count model.
module tb_smash_rate_meter;

  localparam int TW  = 10;
  localparam int TCW = 4;
  localparam int SW  = 24;
  localparam logic [TCW-1:0] CMAX = 4'd15;
`ifdef SMASH_BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, press = 1'b0;
  logic busy, done, busy2, done2;
  logic [TCW-1:0] count, result, best, count2, result2, best2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [TCW-1:0] exp_result = '0;
  logic [TCW-1:0] exp_best   = '0;

  always #5 clk = ~clk;

  smash_rate_meter #(.WINDOW_CYCLES(TW), .CNT_W(TCW)) dut (
    .clk(clk), .rst(rst), .start(start), .press(press),
    .busy(busy), .count(count), .result(result), .done(done), .best(best)
  );

  // Longer window so the 4-bit count can actually reach saturation.
  smash_rate_meter #(.WINDOW_CYCLES(SW), .CNT_W(TCW)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .press(press),
    .busy(busy2), .count(count2), .result(result2), .done(done2), .best(best2)
  );

  function automatic logic [TCW-1:0] best_model(input logic [TCW-1:0] b, input logic [TCW-1:0] r);
    if (!BEST_EN) return '0;
    return (r > b) ? r : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    exp_result = '0;
    exp_best   = '0;
  endtask

  // One full round: arm, optional ARMED wait, TW window cycles, DONE, IDLE.
  task automatic do_round(input bit hold, input logic [TW-1:0] pat, input int arm_wait, input string tag);
    logic [TCW-1:0] e;
    e = '0;
    start = 1'b1;
    tick();
    n_checks++;
    if ({busy, done, count} !== {2'b10, 4'd0}) begin
      n_fail++;
      $display("FAIL %s_armed busy/done/count got %b/%b/%0d want 1/0/0", tag, busy, done, count);
    end
    if (!hold) start = 1'b0;
    repeat (arm_wait) begin
      press = 1'b0;
      tick();
    end
    for (int i = 0; i < TW; i++) begin
      press = pat[i];
      tick();
      if (pat[i] && e != CMAX) e = e + 1'b1;
      n_checks++;
      if (count !== e) begin
        n_fail++;
        $display("FAIL %s_count cyc%0d got %0d want %0d", tag, i, count, e);
      end
      if (i == TW - 1) begin
        exp_result = e;
        n_checks++;
        if ({busy, done, result} !== {2'b01, e}) begin
          n_fail++;
          $display("FAIL %s_done busy/done/result got %b/%b/%0d want 0/1/%0d", tag, busy, done, result, e);
        end
      end else begin
        n_checks++;
        if ({busy, done} !== 2'b10) begin
          n_fail++;
          $display("FAIL %s_run busy/done got %b/%b want 1/0", tag, busy, done);
        end
      end
    end
    press = 1'($urandom_range(0, 1));
    tick();
    press = 1'b0;
    exp_best = best_model(exp_best, e);
    n_checks++;
    if ({busy, done, count, result} !== {2'b00, e, e}) begin
      n_fail++;
      $display("FAIL %s_idle busy/done/count/result got %b/%b/%0d/%0d want 0/0/%0d/%0d",
               tag, busy, done, count, result, e, e);
    end
    n_checks++;
    if (best !== exp_best) begin
      n_fail++;
      $display("FAIL %s_best got %0d want %0d", tag, best, exp_best);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if ({busy, done, count, result, best} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold busy/done/count/result/best got %b/%b/%0d/%0d/%0d want 0", busy, done, count, result, best);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    press = 1'b1;
    repeat (3) tick();
    press = 1'b0;
    n_checks++;
    if (count !== 4'd3) begin
      n_fail++;
      $display("FAIL reset_prep count got %0d want 3", count);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, count, result, best} !== '0) begin
      n_fail++;
      $display("FAIL reset_async busy/done/count/result/best got %b/%b/%0d/%0d/%0d want 0", busy, done, count, result, best);
    end
    #1 rst = 1'b1;
    tick();
    press = 1'b1;
    tick();
    press = 1'b0;
    n_checks++;
    if ({busy, done, count} !== {2'b00, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_idle busy/done/count got %b/%b/%0d want 0/0/0", busy, done, count);
    end
  endtask

  task automatic test_window();
    do_round(1'b0, 10'b10_0001_0101, 1, "window");
    n_checks++;
    if (exp_result !== 4'd4) begin
      n_fail++;
      $display("FAIL window_score got %0d want 4", exp_result);
    end
  endtask

  task automatic test_ignore();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({busy, count, result} !== {1'b0, exp_result, exp_result}) begin
        n_fail++;
        $display("FAIL ignore_idle busy/count/result got %b/%0d/%0d want 0/%0d/%0d", busy, count, result, exp_result, exp_result);
      end
    end
    press = 1'b0;
  endtask

  task automatic test_random();
    logic [TW-1:0] pat;
    for (int r = 0; r < 6; r++) begin
      pat = TW'($urandom) | TW'(1);
      do_round(1'b0, pat, int'($urandom_range(0, 3)), "random");
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] pat;
    for (int r = 0; r < 3; r++) begin
      pat = TW'($urandom) | TW'(1);
      do_round(r < 2, pat, 0, "b2b");
    end
    start = 1'b0;
  endtask

  task automatic test_best();
    do_reset();
    tick();
    do_round(1'b0, 10'b00_0001_1111, 0, "best5");
    do_round(1'b0, 10'b00_0000_0111, 0, "best3");
    do_round(1'b0, 10'b00_0111_1111, 0, "best7");
    n_checks++;
    if (best !== (BEST_EN ? 4'd7 : 4'd0)) begin
      n_fail++;
      $display("FAIL best_final got %0d want %0d", best, BEST_EN ? 7 : 0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < SW; i++) begin
      press = (i < 20);
      tick();
      if (i == TW - 1) begin
        n_checks++;
        if ({done, result} !== {1'b1, 4'd10}) begin
          n_fail++;
          $display("FAIL sat_short done/result got %b/%0d want 1/10", done, result);
        end
      end
      if (i == 14 || i == 19) begin
        n_checks++;
        if ({busy2, count2} !== {1'b1, CMAX}) begin
          n_fail++;
          $display("FAIL sat_count cyc%0d busy/count got %b/%0d want 1/15", i, busy2, count2);
        end
      end
    end
    press = 1'b0;
    n_checks++;
    if ({done2, result2} !== {1'b1, CMAX}) begin
      n_fail++;
      $display("FAIL sat_done done/result got %b/%0d want 1/15", done2, result2);
    end
    tick();
    n_checks++;
    if ({busy2, done2, count2, result2} !== {2'b00, CMAX, CMAX}) begin
      n_fail++;
      $display("FAIL sat_idle busy/done/count/result got %b/%b/%0d/%0d want 0/0/15/15", busy2, done2, count2, result2);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_ignore();
    test_random();
    test_back_to_back();
    test_ignore();
    test_best();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
